median_ctrl: RTL and testbench

MEDIAN_CTRL -- requirements
Module: median_ctrl

---
 rtl/median_ctrl.sv | 131 +++++++++++++
 tb/tb_median_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/median_ctrl.sv
// rtl/median_ctrl.sv - load/sort/done sequencer for an iterative max-extraction median datapath
module median_ctrl #(
    parameter int N_PIXELS = 9
) (
    input  logic CLK,
    input  logic nRST,
    input  logic DSI,
    output logic MED_DSI,
    output logic BYP,
    output logic DSO,
    output logic BUSY,
    output logic ERR
);
    localparam int NPASS = (N_PIXELS + 1) / 2;
    localparam int CW    = $clog2(N_PIXELS);

    localparam logic [CW-1:0] LAST_PIX   = CW'(N_PIXELS);
    localparam logic [CW-1:0] LAST_STEP  = CW'(N_PIXELS - 1);
    localparam logic [CW-1:0] LAST_PASS  = CW'(NPASS - 1);
    localparam logic [CW-1:0] FINAL_STEP = CW'(N_PIXELS - NPASS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] pix_cnt, pix_nxt;
    logic [CW-1:0] pass, pass_nxt;
    logic [CW-1:0] step, step_nxt;
    logic          err_defer, err_defer_nxt;
    logic          err_now;
    logic          err_raise;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            pass      <= '0;
            step      <= '0;
            err_defer <= 1'b0;
            DSO       <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_nxt;
            pass      <= pass_nxt;
            step      <= step_nxt;
            err_defer <= err_defer_nxt;
            DSO       <= (state_nxt == DONE);
            ERR       <= err_now;
        end
    end

    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_cnt;
        pass_nxt  = pass;
        step_nxt  = step;
        err_raise = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (DSI) begin
                    state_nxt = LOAD;
                    pix_nxt   = CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (DSI) begin
                    if (pix_cnt == LAST_PIX - CW'(1)) begin
                        state_nxt = SORT;
                        pix_nxt   = LAST_PIX;
                        pass_nxt  = '0;
                        step_nxt  = '0;
                    end else begin
                        pix_nxt = pix_cnt + CW'(1);
                    end
                end else begin
                    state_nxt = IDLE;
                    err_raise = 1'b1;
                end
            end
            SORT: begin
                // A stray pixel strobe here is flagged but never disturbs the sort.
                err_raise = DSI;
                if (pass == LAST_PASS && step == FINAL_STEP) begin
                    state_nxt = DONE;
                end else if (step == LAST_STEP) begin
                    pass_nxt = pass + CW'(1);
                    step_nxt = '0;
                end else begin
                    step_nxt = step + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An error raised in the last sort cycle would collide with DSO; push it one cycle later.
    always_comb begin
        err_now       = 1'b0;
        err_defer_nxt = 1'b0;
        if (state_nxt == DONE) begin
            err_defer_nxt = err_raise | err_defer;
        end else begin
            err_now = err_raise | err_defer;
        end
    end

    always_comb begin
        MED_DSI = 1'b0;
        BYP     = 1'b1;
        BUSY    = 1'b0;
        case (state)
            IDLE, DONE: begin
                MED_DSI = DSI & nRST;
            end
            LOAD: begin
                MED_DSI = DSI & nRST;
                BUSY    = 1'b1;
            end
            SORT: begin
                // Compare while step < N-1-pass, then shift the extracted maxima back into place.
                BYP  = (step >= LAST_STEP - pass);
                BUSY = 1'b1;
            end
            default: begin
                MED_DSI = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_median_ctrl.sv
// tb/tb_median_ctrl.sv - scoreboard bench: behavioural median datapath plus sorted-window reference
module tb_median_ctrl;
    localparam int N        = 9;
    localparam int NPASS    = (N + 1) / 2;
    localparam int SORT_LEN = (NPASS - 1) * N + (N - NPASS);
    localparam int LAT      = SORT_LEN + 1;
    localparam int BUSY_LEN = (N - 1) + SORT_LEN;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    logic DSI  = 1'b0;
    logic MED_DSI, BYP, DSO, BUSY, ERR;
    logic [7:0] di = 8'h00;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int cyc; int val; } dso_t;
    typedef struct { int cyc; int busy; } err_t;
    dso_t exp_dso[$];
    err_t exp_err[$];

    logic [7:0]          dp [N];
    logic [SORT_LEN-1:0] byp_hist = '0;
    logic [SORT_LEN-1:0] byp_exp;
    int busy_run = 0;
    int last_run = 0;

    median_ctrl #(.N_PIXELS(N)) dut (
        .CLK(CLK), .nRST(nRST), .DSI(DSI), .MED_DSI(MED_DSI),
        .BYP(BYP), .DSO(DSO), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int median_of(input int px[$]);
        int q[$];
        q = px;
        q.sort();
        return q[N/2];
    endfunction

    // Monitor: checks outputs mid-cycle, then advances the datapath model for the coming edge.
    dso_t       de;
    err_t       ee;
    logic [7:0] hi, lo;
    always @(negedge CLK) begin
        if (BUSY) busy_run++;
        else begin
            if (busy_run > 0) last_run = busy_run;
            busy_run = 0;
        end
        if (DSO) begin
            if (exp_dso.size() == 0) check("dso_unexpected", 1, 0);
            else begin
                de = exp_dso.pop_front();
                check("dso_cycle", cyc, de.cyc);
                check("median", dp[N-1], de.val);
            end
            check("byp_pattern", byp_hist, byp_exp);
            check("busy_len", last_run, BUSY_LEN);
            check("dso_busy", BUSY, 0);
            check("dso_err_excl", ERR, 0);
        end
        if (ERR) begin
            if (exp_err.size() == 0) check("err_unexpected", 1, 0);
            else begin
                ee = exp_err.pop_front();
                check("err_cycle", cyc, ee.cyc);
                check("err_busy", BUSY, ee.busy);
            end
        end
        if (MED_DSI) begin
            for (int i = N - 1; i > 0; i--) dp[i] = dp[i-1];
            dp[0] = di;
        end else if (BYP) begin
            hi = dp[N-1];
            for (int i = N - 1; i > 0; i--) dp[i] = dp[i-1];
            dp[0] = hi;
        end else begin
            hi = (dp[N-1] > dp[N-2]) ? dp[N-1] : dp[N-2];
            lo = (dp[N-1] > dp[N-2]) ? dp[N-2] : dp[N-1];
            for (int i = N - 2; i > 0; i--) dp[i] = dp[i-1];
            dp[0]   = lo;
            dp[N-1] = hi;
        end
        byp_hist = {byp_hist[SORT_LEN-2:0], BYP};
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send_window(input int px[$], output int t);
        for (int i = 0; i < N; i++) begin
            DSI = 1'b1;
            di  = 8'(px[i]);
            if (i == N - 1) begin
                t = cyc;
                exp_dso.push_back('{t + LAT, median_of(px)});
            end
            tick();
        end
        DSI = 1'b0;
    endtask

    task automatic idle_until(input int target, input int pulse);
        while (cyc < target) begin
            DSI = (cyc == pulse);
            di  = 8'($urandom);
            if (cyc == pulse) begin
                #1 check("sort_med_dsi", MED_DSI, 0);
            end
            tick();
        end
        DSI = 1'b0;
    endtask

    task automatic abort_window(input int k);
        for (int i = 0; i < k; i++) begin
            DSI = 1'b1;
            di  = 8'($urandom);
            tick();
        end
        DSI = 1'b0;
        exp_err.push_back('{cyc + 1, 0});
        tick();
    endtask

    function automatic void rand_px(output int px[$]);
        px = {};
        for (int i = 0; i < N; i++) px.push_back(int'($urandom_range(0, 255)));
    endfunction

    initial begin
        int t, t2, pc, gap;
        int px[$];
        int s;
        s = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int k = 0; k < N - 1 - p; k++) begin byp_exp[SORT_LEN-1-s] = 1'b0; s++; end
            if (p < NPASS - 1)
                for (int k = 0; k <= p; k++) begin byp_exp[SORT_LEN-1-s] = 1'b1; s++; end
        end
        for (int i = 0; i < N; i++) dp[i] = 8'h00;

        nRST = 1'b0; DSI = 1'b1; di = 8'hAA;
        repeat (3) begin
            tick();
            check("rst_med_dsi", MED_DSI, 0);
        end
        check("rst_busy", BUSY, 0);
        check("rst_byp", BYP, 1);
        check("rst_dso", DSO, 0);
        check("rst_err", ERR, 0);
        nRST = 1'b1; DSI = 1'b0;
        tick();

        px = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        send_window(px, t);
        idle_until(t + LAT + 2, -1);

        px = '{200, 3, 17, 255, 0, 99, 42, 42, 128};
        send_window(px, t);
        idle_until(t + LAT + 2, -1);

        abort_window(5);
        rand_px(px);
        send_window(px, t);
        idle_until(t + LAT + 2, -1);

        rand_px(px);
        send_window(px, t);
        pc = t + 1 + 10;
        exp_err.push_back('{pc + 1, 1});
        idle_until(t + LAT + 2, pc);

        rand_px(px);
        send_window(px, t);
        idle_until(t + 1 + 20, -1);
        nRST = 1'b0;
        void'(exp_dso.pop_back());
        tick();
        nRST = 1'b1;
        check("abandon_busy", BUSY, 0);
        check("abandon_byp", BYP, 1);
        idle_until(cyc + LAT + 5, -1);
        px = '{77, 77, 77, 77, 77, 77, 77, 77, 77};
        send_window(px, t);
        idle_until(t + LAT + 2, -1);

        rand_px(px);
        send_window(px, t);
        idle_until(t + LAT, -1);
        rand_px(px);
        send_window(px, t2);
        idle_until(t2 + LAT + 2, -1);

        rand_px(px);
        send_window(px, t);
        pc = t + SORT_LEN;
        exp_err.push_back('{t + LAT + 1, 0});
        idle_until(t + LAT + 4, pc);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) abort_window(int'($urandom_range(1, N - 1)));
            rand_px(px);
            send_window(px, t);
            pc = -1;
            if ($urandom_range(0, 2) == 0) begin
                pc = t + 1 + int'($urandom_range(0, SORT_LEN - 2));
                exp_err.push_back('{pc + 1, 1});
            end
            gap = int'($urandom_range(0, 3));
            idle_until(t + LAT + gap, pc);
        end

        idle_until(cyc + LAT + 10, -1);
        check("dso_queue_empty", exp_dso.size(), 0);
        check("err_queue_empty", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
